jump_lut_loader: RTL and testbench

Programs the jump-target table that the fetch stage indexes. It accepts a byte stream over a valid/ready handshake: a start index, an entry count, the entry data, and a checksum. Each data byte becomes one registered write (enable, index, data) into the table's write port. It sits between the boot/test loader and the jump table and is the writer end of the table's read-only index-to-address lookup.

---
 rtl/jump_lut_pkg.sv | 24 ++
 rtl/jump_lut_loader.sv | 155 +++++++++++++++
 tb/tb_jump_lut_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/jump_lut_pkg.sv
// jump_lut_pkg: shared types and constants for the jump-table loader.
// State encoding, table geometry and entry types used by the loader and its users.
package jump_lut_pkg;

   localparam int LUT_ADDR_W = 8;
   localparam int LUT_DATA_W = 8;
   localparam int LUT_DEPTH  = 2 ** LUT_ADDR_W;

   // A zero entry count in the header means "load the whole table".
   localparam int CNT_ZERO_FULL = LUT_DEPTH;

   typedef logic [LUT_ADDR_W-1:0] lut_index_t;
   typedef logic [LUT_DATA_W-1:0] jump_addr_t;

   typedef enum logic [2:0] {
      IDLE,
      HDR_IDX,
      HDR_CNT,
      DATA,
      CKSUM,
      DONE
   } ld_state_e;

endpackage

// File: rtl/jump_lut_loader.sv
// jump_lut_loader: turns a header/data/checksum byte stream into table writes.
// Checksum stage is built only when JUMP_LUT_LOADER_CKSUM_EN is defined.
module jump_lut_loader
   import jump_lut_pkg::*;
#(
   parameter int ADDR_W = LUT_ADDR_W,
   parameter int DATA_W = LUT_DATA_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_index,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};

   ld_state_e         state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
   logic [DATA_W-1:0] wr_dat_q, wr_dat_d;
   logic              acc;
   logic              last;

   assign acc  = in_valid & in_ready;
   assign last = (rem_q == ONE_CNT);

   // State register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state: advance on accepted bytes, start only honoured in IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = HDR_IDX;
         HDR_IDX: if (acc) state_d = HDR_CNT;
         HDR_CNT: if (acc) state_d = DATA;
`ifdef JUMP_LUT_LOADER_CKSUM_EN
         DATA:    if (acc && last) state_d = CKSUM;
         CKSUM:   if (acc) state_d = DONE;
`else
         DATA:    if (acc && last) state_d = DONE;
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State-decoded handshake and status outputs
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         HDR_IDX, HDR_CNT, DATA, CKSUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Index/count latching and the one-cycle-late write port
   always_comb begin
      idx_d    = idx_q;
      rem_d    = rem_q;
      wr_en_d  = 1'b0;
      wr_idx_d = wr_idx_q;
      wr_dat_d = wr_dat_q;
      unique case (state_q)
         HDR_IDX: if (acc) idx_d = in_data[ADDR_W-1:0];
         HDR_CNT: if (acc) begin
            rem_d = (in_data == '0) ? FULL_CNT
                                    : {1'b0, in_data[ADDR_W-1:0]};
         end
         DATA: if (acc) begin
            wr_en_d  = 1'b1;
            wr_idx_d = idx_q;
            wr_dat_d = in_data;
            idx_d    = idx_q + 1'b1;
            rem_d    = rem_q - 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         idx_q    <= '0;
         rem_q    <= '0;
         wr_en_q  <= 1'b0;
         wr_idx_q <= '0;
         wr_dat_q <= '0;
      end else begin
         idx_q    <= idx_d;
         rem_q    <= rem_d;
         wr_en_q  <= wr_en_d;
         wr_idx_q <= wr_idx_d;
         wr_dat_q <= wr_dat_d;
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_index = wr_idx_q;
   assign wr_data  = wr_dat_q;

`ifdef JUMP_LUT_LOADER_CKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d;
   logic              err_q, err_d;

   // Running byte sum of the entries and sticky mismatch flag
   always_comb begin
      sum_d = sum_q;
      err_d = err_q;
      unique case (state_q)
         IDLE:    if (start) err_d = 1'b0;
         HDR_CNT: if (acc) sum_d = '0;
         DATA:    if (acc) sum_d = sum_q + in_data;
         CKSUM:   if (acc) err_d = (in_data != sum_q);
         default: ;
      endcase
   end

   // Checksum registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sum_q <= '0;
         err_q <= 1'b0;
      end else begin
         sum_q <= sum_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jump_lut_loader.sv
// tb_jump_lut_loader: scoreboard bench for the jump-table loader.
// Follows JUMP_LUT_LOADER_CKSUM_EN to decide whether a checksum byte is sent.
`timescale 1ns/1ps
module tb_jump_lut_loader;
   import jump_lut_pkg::*;

`ifdef JUMP_LUT_LOADER_CKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic       Clk      = 1'b0;
   logic       Reset    = 1'b1;
   logic       start    = 1'b0;
   logic       in_valid = 1'b0;
   jump_addr_t in_data  = '0;
   logic       in_ready, wr_en, busy, done, err;
   lut_index_t wr_index;
   jump_addr_t wr_data;

   int vecs     = 0;
   int errs     = 0;
   int cyc      = 0;
   int done_cnt = 0;

   typedef struct {
      lut_index_t idx;
      jump_addr_t d;
      int         tag;
   } wexp_t;

   wexp_t      wq[$];
   bit         dq[$];
   jump_addr_t dat[$];
   wexp_t      me;
   bit         mde;

   jump_lut_loader dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_index (wr_index),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   // Monitor: pops expected writes / done events as the DUT presents them
   always @(negedge Clk) begin
      if (!Reset) begin
         if (wr_en) begin
            vecs++;
            if (wq.size() == 0) begin
               errs++;
               $display("FAIL spurious_write got idx=%h data=%h want none",
                        wr_index, wr_data);
            end else begin
               me = wq.pop_front();
               if (wr_index !== me.idx || wr_data !== me.d || cyc != me.tag) begin
                  errs++;
                  $display("FAIL write got idx=%h data=%h cyc=%0d want idx=%h data=%h cyc=%0d",
                           wr_index, wr_data, cyc, me.idx, me.d, me.tag);
               end
            end
         end
         if (done) begin
            vecs++;
            done_cnt++;
            if (dq.size() == 0) begin
               errs++;
               $display("FAIL unexpected_done got done=1 want 0");
            end else begin
               mde = dq.pop_front();
               if (err !== mde || busy !== 1'b0 || in_ready !== 1'b0) begin
                  errs++;
                  $display("FAIL done_flags got err=%b busy=%b rdy=%b want err=%b busy=0 rdy=0",
                           err, busy, in_ready, mde);
               end
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      vecs++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge Clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send(input jump_addr_t b, output int tag);
      int n;
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge Clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         vecs++;
         errs++;
         $display("FAIL accept_timeout got rdy=0 want 1");
      end
      @(posedge Clk);
      tag = cyc;
      #1;
      in_valid = 1'b0;
   endtask

   task automatic run_frame(input lut_index_t idx, input jump_addr_t cnt,
                            input bit bad, input bit gap, input bit st_done);
      lut_index_t i;
      jump_addr_t sum;
      int         tag, d0, n;
      pulse_start();
      check("start_state", {29'd0, err, busy, in_ready}, 32'h3);
      send(idx, tag);
      send(cnt, tag);
      i   = idx;
      sum = '0;
      d0  = done_cnt;
      dq.push_back(CK && bad);
      foreach (dat[k]) begin
         send(dat[k], tag);
         wq.push_back('{i, dat[k], tag + 1});
         i++;
         sum = jump_addr_t'(sum + dat[k]);
         if (gap) begin
            start = 1'b1;
            @(posedge Clk);
            #1;
            start = 1'b0;
         end
      end
      if (CK) send(jump_addr_t'(sum + jump_addr_t'(bad)), tag);
      if (st_done) begin
         start = 1'b1;
         @(posedge Clk);
         #1;
         start = 1'b0;
         check("start_in_done", {31'd0, busy}, 32'h0);
      end
      n = 0;
      while (done_cnt == d0 && n < 8) begin
         @(posedge Clk);
         #1;
         n++;
      end
      vecs++;
      if (done_cnt == d0) begin
         errs++;
         $display("FAIL done_timeout got no done want pulse");
      end
   endtask

   initial begin
      int tag;
      repeat (3) @(posedge Clk);
      #1;
      check("reset_outs",
            {11'd0, in_ready, wr_en, wr_index, wr_data, busy, done, err}, '0);
      Reset = 1'b0;
      @(posedge Clk);
      #1;
      check("idle_ready", {30'd0, in_ready, busy}, 32'h0);

      dat = {8'h05, 8'h0E, 8'h0C};
      run_frame(8'h10, 8'h03, 1'b0, 1'b0, 1'b1);
      check("idle_ready2", {30'd0, in_ready, busy}, 32'h0);
      run_frame(8'h10, 8'h03, 1'b1, 1'b0, 1'b0);
      check("err_hold", {31'd0, err}, {31'd0, CK});

      dat = {8'hA1, 8'hA2, 8'hA3};
      run_frame(8'hFE, 8'h03, 1'b0, 1'b0, 1'b0);

      dat.delete();
      for (int k = 0; k < CNT_ZERO_FULL; k++) dat.push_back(jump_addr_t'(k * 7 + 3));
      run_frame(8'h40, 8'h00, 1'b0, 1'b0, 1'b0);

      dat = {8'h11, 8'h22, 8'h33, 8'h44};
      run_frame(8'h80, 8'h04, 1'b0, 1'b1, 1'b0);

      pulse_start();
      send(8'h30, tag);
      send(8'h04, tag);
      send(8'hC1, tag);
      wq.push_back('{8'h30, 8'hC1, tag + 1});
      send(8'hC2, tag);
      wq.push_back('{8'h31, 8'hC2, tag + 1});
      @(negedge Clk);
      #1;
      Reset = 1'b1;
      #1;
      check("reset_mid",
            {11'd0, in_ready, wr_en, wr_index, wr_data, busy, done, err}, '0);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      check("abort_writes", wq.size(), 32'd0);
      @(posedge Clk);
      #1;
      check("abort_idle", {30'd0, in_ready, busy}, 32'h0);

      dat = {8'h77, 8'h66};
      run_frame(8'h05, 8'h02, 1'b0, 1'b0, 1'b0);

      repeat (3) @(posedge Clk);
      #1;
      check("queues_empty", wq.size() + dq.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
